// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, framing bit levels and the
// default data width.
package uart_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit index counter for the TX frame: clearable, enabled up-counter with
// a flag marking the last data bit.
module uart_tx_bit_cnt #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 3
) (
  input  logic             clck,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == LAST_IDX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity
// from an external registered calculator, stop bit; registered line and busy.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int   DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_bit,
  output logic [DATA_WIDTH-1:0] par_data,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t        state;
  logic             par_en_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_next;
  logic             bit_last;
  logic             accept;

  // A new byte is taken only when the line is idle or finishing its stop bit.
  assign accept   = data_valid && ((state == IDLE) || (state == STOP));
  assign bit_next = bit_cnt + CNT_W'(1);

  uart_tx_bit_cnt #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_bit_cnt (
    .clck   (clck),
    .rst    (rst),
    .clear  (state != DATA),
    .enable (state == DATA),
    .count  (bit_cnt),
    .last   (bit_last)
  );

  // tx_out is loaded one edge ahead with the bit the next state presents.
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_out   <= IDLE_LEVEL;
      busy     <= 1'b0;
      par_data <= '0;
      par_en_q <= 1'b0;
    end else if (accept) begin
      state    <= START;
      tx_out   <= START_BIT;
      busy     <= 1'b1;
      par_data <= p_data;
      par_en_q <= par_en;
    end else begin
      case (state)
        START: begin
          state  <= DATA;
          tx_out <= par_data[0];
        end
        DATA: begin
          if (bit_last) begin
            if (par_en_q) begin
              state  <= PARITY;
              tx_out <= par_bit;
            end else begin
              state  <= STOP;
              tx_out <= IDLE_LEVEL;
            end
          end else begin
            tx_out <= par_data[bit_next];
          end
        end
        PARITY: begin
          state  <= STOP;
          tx_out <= IDLE_LEVEL;
        end
        STOP: begin
          state  <= IDLE;
          tx_out <= IDLE_LEVEL;
          busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          tx_out <= IDLE_LEVEL;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames plus random traffic
// compared cycle by cycle against a queue-of-bits frame model.
module tb_uart_tx_ctrl;

  logic       clck = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_bit;
  logic [7:0] par_data;
  logic       tx_out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  bit         exp_q[$];
  logic [7:0] exp_par_data;

  uart_tx_ctrl dut (
    .clck       (clck),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_bit    (par_bit),
    .par_data   (par_data),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clck = ~clck;

  // Environment model of the registered even-parity calculator.
  always_ff @(posedge clck or posedge rst) begin
    if (rst) par_bit <= 1'b0;
    else     par_bit <= ^par_data;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [7:0] d, input logic pe);
    data_valid = dv;
    p_data     = d;
    par_en     = pe;
  endtask

  task automatic checkLine(input string tag);
    checkOutput({tag, ".tx_out"}, {7'd0, tx_out}, {7'd0, (exp_q.size() != 0) ? exp_q[0] : 1'b1});
    checkOutput({tag, ".busy"}, {7'd0, busy}, {7'd0, exp_q.size() != 0});
    checkOutput({tag, ".par_data"}, par_data, exp_par_data);
  endtask

  // One clock: the model retires the current bit and, on acceptance, queues
  // the complete frame derived from the byte and parity rule.
  task automatic cycle(input string tag);
    bit         accept;
    logic [7:0] d;
    logic       pe;
    accept = !rst && data_valid && (exp_q.size() <= 1);
    d  = p_data;
    pe = par_en;
    @(posedge clck);
    if (!rst) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (accept) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(^d);
        exp_q.push_back(1'b1);
        exp_par_data = d;
      end
    end
    #1;
    checkLine(tag);
  endtask

  task automatic assertReset();
    rst = 1'b1;
    exp_q.delete();
    exp_par_data = 8'h00;
    #1;
    checkLine("reset_async");
  endtask

  task automatic releaseReset();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    exp_par_data = 8'h00;
    applyStimulus(1'b0, 8'h00, 1'b0);
    #12;
    checkLine("reset_init");
    @(posedge clck); #1;
    releaseReset();

    // Idle, then a mid-run reset pulse, then 20 quiet cycles.
    for (int i = 0; i < 3; i++) cycle("idle_pre");
    assertReset();
    @(posedge clck); #1;
    releaseReset();
    for (int i = 0; i < 20; i++) cycle("idle");

    // 0xA5 with parity: 11-cycle frame.
    applyStimulus(1'b1, 8'hA5, 1'b1);
    cycle("a5_accept");
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) cycle("a5_frame");

    // 0x3C without parity: 10-cycle frame.
    applyStimulus(1'b1, 8'h3C, 1'b0);
    cycle("3c_accept");
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 11; i++) cycle("3c_frame");

    // Back-to-back: 0xFF then 0x00 accepted during the stop bit.
    applyStimulus(1'b1, 8'hFF, 1'b0);
    cycle("ff_accept");
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) cycle("ff_frame");
    checkOutput("b2b_in_stop", {7'd0, tx_out}, 8'd1);
    applyStimulus(1'b1, 8'h00, 1'b1);
    cycle("b2b_accept");
    checkOutput("b2b_start", {7'd0, tx_out}, 8'd0);
    checkOutput("b2b_busy", {7'd0, busy}, 8'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) cycle("00_frame");

    // 0x55 strobe during DATA of a 0x81 frame is ignored.
    applyStimulus(1'b1, 8'h81, 1'b0);
    cycle("81_accept");
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle("81_frame");
    applyStimulus(1'b1, 8'h55, 1'b1);
    cycle("81_ignore");
    applyStimulus(1'b0, 8'h55, 1'b1);
    for (int i = 0; i < 8; i++) cycle("81_rest");
    checkOutput("81_par_data_kept", par_data, 8'h81);

    // Reset at data bit 4 of 0xF0, then a clean 0x0F frame.
    applyStimulus(1'b1, 8'hF0, 1'b1);
    cycle("f0_accept");
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle("f0_frame");
    assertReset();
    @(posedge clck); #1;
    checkLine("f0_in_reset");
    releaseReset();
    for (int i = 0; i < 4; i++) cycle("f0_after");
    applyStimulus(1'b1, 8'h0F, 1'b1);
    cycle("0f_accept");
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) cycle("0f_frame");

    // Random traffic, including strobes that land mid-frame and in STOP.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) == 0, 8'($urandom), 1'($urandom));
      cycle("random");
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) cycle("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
